// File: rtl/intr_sequencer.sv
// rtl/intr_sequencer.sv - prioritised interrupt entry: commit, drain D/A/M, redirect to SIH, hold until RETI
// Optional INTR_SEQ_EDGE_EN: requests come from an edge-captured pending register instead of raw IRQ levels.
module intr_sequencer #(
   parameter int DBITS        = 16,
   parameter int NSRC         = 3,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NSRC-1:0]  irq,
   input  logic             ie,
   input  logic [DBITS-1:0] pc_next,
   input  logic [DBITS-1:0] sih,
   input  logic             reti_done,
   output logic             flush,
   output logic             redirect,
   output logic [DBITS-1:0] redirect_pc,
   output logic             scs_enter,
   output logic             sra_we,
   output logic [DBITS-1:0] sra_val,
   output logic [DBITS-1:0] sii_val,
   output logic [NSRC-1:0]  iack,
   output logic             busy
);
   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DRAIN  = 2'b01,
      VECTOR = 2'b10,
      INSVC  = 2'b11
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [NSRC-1:0] winner;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] sel_oh;
   logic [3:0]      sel_num;
   logic            take;

`ifdef INTR_SEQ_EDGE_EN
   logic [NSRC-1:0] irq_q;
   logic [NSRC-1:0] pending;

   // Clear the committed source first so a fresh edge in the same cycle is not lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q   <= '0;
         pending <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~({NSRC{sra_we}} & winner)) | (irq & ~irq_q);
      end
   end

   assign req = pending;
`else
   assign req = irq;
`endif

   always_comb begin
      sel_oh  = '0;
      sel_num = 4'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_num   = 4'(i + 1);
         end
      end
   end

   assign take = (state == IDLE) && ie && (|req);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      flush       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      iack        = '0;
      busy        = (state != IDLE);
      case (state)
         IDLE: begin
            if (take) state_nxt = DRAIN;
         end
         DRAIN: begin
            flush = 1'b1;
            if (cnt == '0) state_nxt = VECTOR;
         end
         VECTOR: begin
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = sih;
            state_nxt   = INSVC;
         end
         INSVC: begin
            iack = winner;
            if (reti_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Entry context is frozen here until the next entry; no preemption.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         scs_enter <= 1'b0;
         sra_we    <= 1'b0;
         winner    <= '0;
         sii_val   <= '0;
         sra_val   <= '0;
      end else begin
         scs_enter <= take;
         sra_we    <= take;
         if (take) begin
            cnt     <= CW'(DRAIN_CYCLES - 1);
            winner  <= sel_oh;
            sii_val <= {{(DBITS-4){1'b0}}, sel_num};
            sra_val <= pc_next;
         end else if (state == DRAIN && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_intr_sequencer.sv
// tb/tb_intr_sequencer.sv - vector table plus scoreboard bench for intr_sequencer
// Also exercises the INTR_SEQ_EDGE_EN pending behaviour when that macro is defined.
module tb_intr_sequencer;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  irq;
   logic        ie;
   logic [15:0] pc_next;
   logic [15:0] sih;
   logic        reti_done;
   logic        flush, redirect, scs_enter, sra_we, busy;
   logic [15:0] redirect_pc, sra_val, sii_val;
   logic [2:0]  iack;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        ie;
      logic [2:0]  irq;
      logic [15:0] pc;
      logic [15:0] sih;
      logic [15:0] sii;
      logic [2:0]  iack;
      logic        enter;
      logic        drop_ie;
   } vec_t;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] sih;
      logic [15:0] sii;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[5];

   intr_sequencer #(.DBITS(16), .NSRC(3), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .ie(ie), .pc_next(pc_next),
      .sih(sih), .reti_done(reti_done), .flush(flush), .redirect(redirect),
      .redirect_pc(redirect_pc), .scs_enter(scs_enter), .sra_we(sra_we),
      .sra_val(sra_val), .sii_val(sii_val), .iack(iack), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every redirect must match the oldest outstanding entry expectation.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && redirect === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_redirect: got redirect_pc %0h expected no redirect", redirect_pc);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_redirect_pc", 32'(redirect_pc), 32'(mon_e.sih));
            chk("sb_sra_val", 32'(sra_val), 32'(mon_e.pc));
            chk("sb_sii_val", 32'(sii_val), 32'(mon_e.sii));
         end
      end
   end

   task automatic push_exp(input logic [15:0] pc, input logic [15:0] h, input logic [15:0] n);
      exp_t e;
      e.pc = pc; e.sih = h; e.sii = n;
      sb.push_back(e);
   endtask

   task automatic pulse_reti();
      @(posedge clk); #1;
      reti_done = 1'b1;
      @(posedge clk); #1;
      reti_done = 1'b0;
   endtask

   task automatic wait_insvc(input string nm, input logic [2:0] exp_iack);
      int n = 0;
      while (iack == 3'b000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(iack), 32'(exp_iack));
   endtask

   task automatic run_vec(input vec_t v);
      logic act = 1'b0;
      ie = v.ie; irq = v.irq; pc_next = v.pc; sih = v.sih;
      if (v.enter) begin
         push_exp(v.pc, v.sih, v.sii);
         @(posedge clk); #1;
         if (v.drop_ie) ie = 1'b0;
         @(negedge clk);
         chk("entry_scs_enter", 32'(scs_enter), 32'd1);
         chk("entry_sra_we", 32'(sra_we), 32'd1);
         chk("drain1_flush", 32'(flush), 32'd1);
         @(negedge clk);
         chk("drain2_pulse_gone", 32'({scs_enter, sra_we, redirect}), 32'd0);
         chk("drain2_flush", 32'(flush), 32'd1);
         @(negedge clk);
         chk("drain3_flush_redirect", 32'({flush, redirect}), 32'b10);
         @(negedge clk);
         chk("vector_flush_redirect", 32'({flush, redirect}), 32'b11);
         @(negedge clk);
         chk("insvc_iack", 32'(iack), 32'(v.iack));
         chk("insvc_flush_redirect", 32'({flush, redirect}), 32'd0);
         repeat (3) @(negedge clk);
         chk("insvc_hold_iack", 32'(iack), 32'(v.iack));
         chk("insvc_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
         irq = 3'b000;
         reti_done = 1'b1;
         @(posedge clk); #1;
         reti_done = 1'b0;
         @(negedge clk);
         chk("reti_idle", 32'({busy, iack}), 32'd0);
      end else begin
         repeat (20) begin
            @(negedge clk);
            act = act | busy | flush | redirect | scs_enter | sra_we | (|iack);
         end
         chk("ie0_quiet", 32'(act), 32'd0);
         @(posedge clk); #1;
         irq = 3'b000;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; irq = 3'b000; ie = 1'b0; pc_next = 16'h0; sih = 16'h0; reti_done = 1'b0;

      vecs[0] = '{1'b1, 3'b001, 16'h0240, 16'h0100, 16'h0001, 3'b001, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 3'b110, 16'h1234, 16'h0200, 16'h0002, 3'b010, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 3'b111, 16'h5555, 16'h0300, 16'h0000, 3'b000, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 3'b100, 16'hBEEF, 16'h0400, 16'h0003, 3'b100, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 3'b011, 16'h8000, 16'hFFFE, 16'h0001, 3'b001, 1'b1, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset_ctrl", 32'({flush, redirect, scs_enter, sra_we, busy, iack}), 32'd0);
      chk("reset_sra_val", 32'(sra_val), 32'd0);
      chk("reset_sii_val", 32'(sii_val), 32'd0);
      chk("reset_redirect_pc", 32'(redirect_pc), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

`ifndef INTR_SEQ_EDGE_EN
      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // RETI_DONE while idle does nothing.
      ie = 1'b1; irq = 3'b000;
      pulse_reti();
      @(negedge clk);
      chk("reti_in_idle", 32'({busy, scs_enter, sra_we, flush}), 32'd0);

      // RETI with IRQ still high: one idle cycle, then re-entry; IRQ dropped during DRAIN.
      pc_next = 16'h0A00; sih = 16'h0C00; irq = 3'b001;
      push_exp(16'h0A00, 16'h0C00, 16'h0001);
      wait_insvc("reentry_first_iack", 3'b001);
      pulse_reti();
      @(negedge clk);
      chk("reentry_idle_gap", 32'(busy), 32'd0);
      pc_next = 16'h0A04;
      push_exp(16'h0A04, 16'h0C00, 16'h0001);
      @(posedge clk); #1;
      irq = 3'b000;
      @(negedge clk);
      chk("reentry_scs_enter", 32'(scs_enter), 32'd1);
      wait_insvc("reentry_second_iack", 3'b001);
      pulse_reti();

      // Asynchronous reset while DRAIN counter is 1.
      irq = 3'b001; pc_next = 16'h7777;
      @(posedge clk); #1;
      irq = 3'b000;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_reset_flush", 32'(flush), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_ctrl", 32'({flush, redirect, scs_enter, sra_we, busy, iack}), 32'd0);
      chk("async_reset_sra_val", 32'(sra_val), 32'd0);
      chk("async_reset_sii_val", 32'(sii_val), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_reset_idle", 32'({busy, flush, redirect}), 32'd0);
`endif

      // One-cycle IRQ[2] pulse during service.
      @(posedge clk); #1;
      ie = 1'b1; irq = 3'b001; pc_next = 16'h0300; sih = 16'h0900;
      push_exp(16'h0300, 16'h0900, 16'h0001);
      wait_insvc("pulse_first_iack", 3'b001);
      @(posedge clk); #1;
      irq = 3'b000;
      @(posedge clk); #1;
      irq = 3'b100;
      @(posedge clk); #1;
      irq = 3'b000;
      pc_next = 16'h0310;
`ifdef INTR_SEQ_EDGE_EN
      push_exp(16'h0310, 16'h0900, 16'h0003);
`endif
      pulse_reti();
`ifdef INTR_SEQ_EDGE_EN
      wait_insvc("pulse_serviced_iack", 3'b100);
      chk("pulse_sii_val", 32'(sii_val), 32'h0003);
      pulse_reti();
`else
      begin
         logic act = 1'b0;
         repeat (12) begin
            @(negedge clk);
            act = act | busy | scs_enter;
         end
         chk("pulse_lost_level", 32'(act), 32'd0);
      end
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
